// File: rtl/read_reorder_buffer_pkg.sv
// Shared types and sizes for the read return path.
// DATA_WIDTH / INDEX_WIDTH are also used by front_end, so the tag and data
// widths on both sides of the request/return path cannot drift apart.
package read_reorder_buffer_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_WIDTH = 6;
    localparam int DEPTH       = 2 ** INDEX_WIDTH;

    // Life of one tag: FREE -> PENDING (allocated) -> DONE (data back) -> FREE (popped)
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } entry_state_e;

endpackage

// File: rtl/read_reorder_buffer_if.sv
// Handshake bundle of the reorder buffer.
//   alloc_*  : tag allocation towards front_end
//   cpl_*    : out-of-order completions from the back end
//   rd_*     : in-order read data towards the requester
//   occupancy: allocated entries not yet moved to the output register
// master = surrounding logic, slave = the reorder buffer.
interface read_reorder_buffer_if;
    import read_reorder_buffer_pkg::*;

    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [INDEX_WIDTH-1:0] alloc_index;
    logic                   cpl_valid;
    logic [INDEX_WIDTH-1:0] cpl_index;
    logic [DATA_WIDTH-1:0]  cpl_data;
    logic                   cpl_error;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [INDEX_WIDTH-1:0] rd_index;
    logic [INDEX_WIDTH:0]   occupancy;

    modport master (
        output alloc_valid, cpl_valid, cpl_index, cpl_data, rd_ready,
        input  alloc_ready, alloc_index, cpl_error, rd_valid, rd_data, rd_index, occupancy
    );

    modport slave (
        input  alloc_valid, cpl_valid, cpl_index, cpl_data, rd_ready,
        output alloc_ready, alloc_index, cpl_error, rd_valid, rd_data, rd_index, occupancy
    );
endinterface

// File: rtl/read_reorder_buffer_rob_data_ram.sv
// Completion data store: DEPTH x DATA_WIDTH.
//   clk          : clock
//   we/waddr/wdata : synchronous write port (accepted completion)
//   raddr/rdata  : asynchronous read port (head entry)
// Contents are not reset; an entry is only read after its completion wrote it.
module rob_data_ram #(
    parameter int DEPTH       = 64,
    parameter int INDEX_WIDTH = 6,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [INDEX_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]  rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/read_reorder_buffer.sv
// Read reorder buffer: hands out tags in order, accepts completions in any
// order and releases data strictly in allocation order.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset, drops all entries and output data
//   bus : slave side of read_reorder_buffer_if (alloc / cpl / rd / occupancy)
module read_reorder_buffer
    import read_reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    read_reorder_buffer_if.slave  bus
);
    entry_state_e           state_q [DEPTH];
    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [INDEX_WIDTH:0]   head_q, tail_q;
    logic [INDEX_WIDTH-1:0] head_idx, tail_idx;
    logic                   rd_valid_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic [INDEX_WIDTH-1:0] rd_index_q;
    logic                   cpl_error_q;
    logic [INDEX_WIDTH:0]   occupancy;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   alloc_fire, cpl_ok, load;

    assign head_idx  = head_q[INDEX_WIDTH-1:0];
    assign tail_idx  = tail_q[INDEX_WIDTH-1:0];
    assign occupancy = tail_q - head_q;

    assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
    // Checked against pre-edge state: a completion racing its own allocation is an error.
    assign cpl_ok     = bus.cpl_valid && (state_q[bus.cpl_index] == PENDING);
    assign load       = (state_q[head_idx] == DONE) && (!rd_valid_q || bus.rd_ready);

    rob_data_ram #(
        .DEPTH       (DEPTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (cpl_ok),
        .waddr (bus.cpl_index),
        .wdata (bus.cpl_data),
        .raddr (head_idx),
        .rdata (head_data)
    );

    // The three state writes never target the same entry in one cycle:
    // head is DONE, the completion target is PENDING, and tail is FREE
    // whenever allocation is allowed (not full).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
            head_q      <= '0;
            tail_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_index_q  <= '0;
            cpl_error_q <= 1'b0;
        end else begin
            if (load) begin
                state_q[head_idx] <= FREE;
                head_q            <= head_q + 1'b1;
                rd_valid_q        <= 1'b1;
                rd_data_q         <= head_data;
                rd_index_q        <= head_idx;
            end else if (bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
            if (cpl_ok) state_q[bus.cpl_index] <= DONE;
            if (alloc_fire) begin
                state_q[tail_idx] <= PENDING;
                tail_q            <= tail_q + 1'b1;
            end
            cpl_error_q <= bus.cpl_valid && !cpl_ok;
        end
    end

    assign bus.alloc_ready = (occupancy != (INDEX_WIDTH+1)'(DEPTH));
    assign bus.alloc_index = tail_idx;
    assign bus.occupancy   = occupancy;
    assign bus.cpl_error   = cpl_error_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_index    = rd_index_q;
endmodule

// File: tb/tb_read_reorder_buffer.sv
module tb_read_reorder_buffer;
    import read_reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    read_reorder_buffer_if bus ();

    read_reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.alloc_valid = 1'b1;
            step();
        end
        bus.alloc_valid = 1'b0;
    endtask

    task automatic cpl(input int idx, input logic [31:0] data);
        bus.cpl_valid = 1'b1;
        bus.cpl_index = INDEX_WIDTH'(idx);
        bus.cpl_data  = data;
        step();
        bus.cpl_valid = 1'b0;
    endtask

    task automatic expect_rd(input string tag, input int idx, input logic [31:0] data);
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_index"}, 32'(bus.rd_index), 32'(idx));
        chk({tag, "_data"},  bus.rd_data, data);
    endtask

    initial begin
        bus.alloc_valid = 1'b0;
        bus.cpl_valid   = 1'b0;
        bus.cpl_index   = '0;
        bus.cpl_data    = '0;
        bus.rd_ready    = 1'b1;

        // 1 reset
        do_reset();
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("rst_rd_valid",    32'(bus.rd_valid),    32'd0);
        chk("rst_occupancy",   32'(bus.occupancy),   32'd0);
        chk("rst_alloc_index", 32'(bus.alloc_index), 32'd0);
        chk("rst_cpl_error",   32'(bus.cpl_error),   32'd0);
        chk("rst_rd_data",     bus.rd_data,          32'd0);

        // 2 in order
        alloc_n(3);
        chk("io_occupancy", 32'(bus.occupancy), 32'd3);
        chk("io_alloc_index", 32'(bus.alloc_index), 32'd3);
        cpl(0, 32'hA0);
        chk("io_rd_early", 32'(bus.rd_valid), 32'd0);
        cpl(1, 32'hA1);
        expect_rd("io0", 0, 32'hA0);
        cpl(2, 32'hA2);
        expect_rd("io1", 1, 32'hA1);
        step();
        expect_rd("io2", 2, 32'hA2);
        step();
        chk("io_drained", 32'(bus.rd_valid), 32'd0);
        chk("io_occ_end", 32'(bus.occupancy), 32'd0);

        // 3 out of order
        do_reset();
        alloc_n(4);
        cpl(3, 32'h13);
        chk("ooo_wait3", 32'(bus.rd_valid), 32'd0);
        cpl(1, 32'h11);
        chk("ooo_wait1", 32'(bus.rd_valid), 32'd0);
        cpl(2, 32'h12);
        chk("ooo_wait2", 32'(bus.rd_valid), 32'd0);
        cpl(0, 32'h10);
        chk("ooo_wait0", 32'(bus.rd_valid), 32'd0);
        step();
        expect_rd("ooo0", 0, 32'h10);
        step();
        expect_rd("ooo1", 1, 32'h11);
        step();
        expect_rd("ooo2", 2, 32'h12);
        step();
        expect_rd("ooo3", 3, 32'h13);
        step();
        chk("ooo_drained", 32'(bus.rd_valid), 32'd0);

        // 4 full / wrap
        do_reset();
        alloc_n(64);
        chk("full_ready", 32'(bus.alloc_ready), 32'd0);
        chk("full_occ",   32'(bus.occupancy),   32'd64);
        bus.alloc_valid = 1'b1;
        step();
        bus.alloc_valid = 1'b0;
        chk("full_extra_occ",   32'(bus.occupancy),   32'd64);
        chk("full_extra_index", 32'(bus.alloc_index), 32'd0);
        cpl(0, 32'h40);
        chk("full_ready_hold", 32'(bus.alloc_ready), 32'd0);
        step();
        expect_rd("full_pop0", 0, 32'h40);
        chk("full_ready_back", 32'(bus.alloc_ready), 32'd1);
        chk("full_occ63",      32'(bus.occupancy),   32'd63);
        chk("full_wrap_index", 32'(bus.alloc_index), 32'd0);
        alloc_n(1);
        chk("wrap_occ", 32'(bus.occupancy), 32'd64);
        chk("wrap_ready", 32'(bus.alloc_ready), 32'd0);
        chk("wrap_rd_idle", 32'(bus.rd_valid), 32'd0);
        bus.rd_ready = 1'b0;
        cpl(0, 32'h55);
        for (int i = 1; i < 64; i++) cpl(i, 32'h200 + 32'(i));
        chk("wrap_hold_occ", 32'(bus.occupancy), 32'd63);
        bus.rd_ready = 1'b1;
        for (int i = 1; i < 64; i++) begin
            expect_rd("wrap_seq", i, 32'h200 + 32'(i));
            step();
        end
        expect_rd("wrap_tag0", 0, 32'h55);
        step();
        chk("wrap_drained", 32'(bus.rd_valid), 32'd0);
        chk("wrap_occ_end", 32'(bus.occupancy), 32'd0);

        // 5 errors
        do_reset();
        cpl(5, 32'hDEAD);
        chk("err_free", 32'(bus.cpl_error), 32'd1);
        chk("err_free_occ", 32'(bus.occupancy), 32'd0);
        step();
        chk("err_pulse_end", 32'(bus.cpl_error), 32'd0);
        alloc_n(2);
        cpl(1, 32'h71);
        chk("err_ok_cpl", 32'(bus.cpl_error), 32'd0);
        cpl(1, 32'h99);
        chk("err_done", 32'(bus.cpl_error), 32'd1);
        // completion racing the allocation of the same tag
        bus.alloc_valid = 1'b1;
        cpl(2, 32'hBAD);
        bus.alloc_valid = 1'b0;
        chk("err_race", 32'(bus.cpl_error), 32'd1);
        chk("err_race_occ", 32'(bus.occupancy), 32'd3);
        cpl(0, 32'h70);
        chk("err_clear", 32'(bus.cpl_error), 32'd0);
        cpl(2, 32'h72);
        expect_rd("err0", 0, 32'h70);
        step();
        expect_rd("err1", 1, 32'h71);
        step();
        expect_rd("err2", 2, 32'h72);

        // 6 backpressure / reset
        do_reset();
        bus.rd_ready = 1'b0;
        alloc_n(3);
        cpl(0, 32'h60);
        cpl(1, 32'h61);
        cpl(2, 32'h62);
        for (int i = 0; i < 10; i++) begin
            expect_rd("bp_hold", 0, 32'h60);
            chk("bp_occ", 32'(bus.occupancy), 32'd2);
            step();
        end
        bus.rd_ready = 1'b1;
        step();
        expect_rd("bp_next", 1, 32'h61);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.rd_valid),    32'd0);
        chk("mid_rst_occ",   32'(bus.occupancy),   32'd0);
        chk("mid_rst_index", 32'(bus.alloc_index), 32'd0);
        step();
        chk("mid_rst_quiet", 32'(bus.rd_valid), 32'd0);
        alloc_n(1);
        cpl(0, 32'h88);
        step();
        expect_rd("post_rst", 0, 32'h88);
        step();
        chk("post_rst_drained", 32'(bus.rd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
